// File: rtl/mac_dot_sequencer_pkg.sv
// mac_dot_sequencer_pkg: shared state encoding, exception codes and number
// format field helpers for the MAF dot-product sequencer.
// Word layout: {exception, sign, exponent, mantissa without hidden 1}.
package mac_dot_sequencer_pkg;

  localparam int unsigned DEF_SIZE_MANTISSA        = 24;
  localparam int unsigned DEF_SIZE_EXPONENT        = 8;
  localparam int unsigned DEF_SIZE_EXCEPTION_FIELD = 2;
  localparam int unsigned DEF_SIZE_LEN             = 8;

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'd0,
    STATE_WAIT_ELEM = 2'd1,
    STATE_ISSUE     = 2'd2,
    STATE_DONE      = 2'd3
  } state_e;

  localparam logic [1:0] EXC_ZERO     = 2'b00;
  localparam logic [1:0] EXC_NORMAL   = 2'b01;
  localparam logic [1:0] EXC_INFINITY = 2'b10;
  localparam logic [1:0] EXC_NAN      = 2'b11;

  // Lowest bit of the exception field within a word.
  function automatic int unsigned exc_lsb(input int unsigned size_mantissa,
                                          input int unsigned size_exponent);
    return size_mantissa + size_exponent;
  endfunction

  // Bit position of the sign within a word.
  function automatic int unsigned sign_pos(input int unsigned size_mantissa,
                                           input int unsigned size_exponent);
    return size_mantissa + size_exponent - 1;
  endfunction

  function automatic logic is_nan(input logic [1:0] exc);
    return exc == EXC_NAN;
  endfunction

endpackage

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams a/b operand pairs into an external fused
// multiply-accumulate unit, feeding each result back as the next C operand,
// so result = init +/- sum(a_i * b_i) over a programmable vector length.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start_i/length_i/init_i/sub_i   vector command, sampled in IDLE
//   elem_valid_i/elem_ready_o/a_i/b_i  operand pair handshake
//   mac_a_o/mac_b_o/mac_c_o/mac_sub_o  registered MAF operands
//   mac_result_i             MAF result, sampled mac_latency cycles after issue
//   busy_o/done_o/result_o/count_o    status and completion
//
// Optional feature: define MAC_SEQ_NAN_EARLY_EXIT_EN to stop issuing to the
// MAF once a NaN result is captured; remaining elements are drained one per
// cycle and the NaN word is returned.
module mac_dot_sequencer
  import mac_dot_sequencer_pkg::*;
#(
  parameter int unsigned size_mantissa        = DEF_SIZE_MANTISSA,
  parameter int unsigned size_exponent        = DEF_SIZE_EXPONENT,
  parameter int unsigned size_exception_field = DEF_SIZE_EXCEPTION_FIELD,
  parameter int unsigned mac_latency          = 0,
  parameter int unsigned size_len             = DEF_SIZE_LEN,
  localparam int unsigned size = size_exponent + size_mantissa + size_exception_field
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [size_len-1:0] length_i,
  input  logic [size-1:0]     init_i,
  input  logic                sub_i,
  input  logic                elem_valid_i,
  output logic                elem_ready_o,
  input  logic [size-1:0]     a_i,
  input  logic [size-1:0]     b_i,
  output logic [size-1:0]     mac_a_o,
  output logic [size-1:0]     mac_b_o,
  output logic [size-1:0]     mac_c_o,
  output logic                mac_sub_o,
  input  logic [size-1:0]     mac_result_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [size-1:0]     result_o,
  output logic [size_len-1:0] count_o
);

  localparam int unsigned wait_w = (mac_latency > 0) ? $clog2(mac_latency + 1) : 1;

  localparam logic [1:0] S_IDLE      = 2'(STATE_IDLE);
  localparam logic [1:0] S_WAIT_ELEM = 2'(STATE_WAIT_ELEM);
  localparam logic [1:0] S_ISSUE     = 2'(STATE_ISSUE);
  localparam logic [1:0] S_DONE      = 2'(STATE_DONE);

  logic [1:0]          state_q, state_d;
  logic [size-1:0]     acc_q, acc_d;
  logic [size_len-1:0] remaining_q, remaining_d;
  logic [wait_w-1:0]   wait_q, wait_d;
  logic [size-1:0]     mac_a_d, mac_b_d, mac_c_d, result_d;
  logic                mac_sub_d, busy_d, done_d, ready_d;
  logic [size_len-1:0] count_d;
  logic                nan_q, nan_d;
  logic                res_nan;

`ifdef MAC_SEQ_NAN_EARLY_EXIT_EN
  logic [size_exception_field-1:0] res_exc;
  assign res_exc = mac_result_i[exc_lsb(size_mantissa, size_exponent) +: size_exception_field];
  assign res_nan = is_nan(2'(res_exc));
`else
  assign res_nan = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      remaining_q  <= '0;
      wait_q       <= '0;
      nan_q        <= 1'b0;
      mac_a_o      <= '0;
      mac_b_o      <= '0;
      mac_c_o      <= '0;
      mac_sub_o    <= 1'b0;
      result_o     <= '0;
      count_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      elem_ready_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      remaining_q  <= remaining_d;
      wait_q       <= wait_d;
      nan_q        <= nan_d;
      mac_a_o      <= mac_a_d;
      mac_b_o      <= mac_b_d;
      mac_c_o      <= mac_c_d;
      mac_sub_o    <= mac_sub_d;
      result_o     <= result_d;
      count_o      <= count_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      elem_ready_o <= ready_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    nan_d       = nan_q;
    mac_a_d     = mac_a_o;
    mac_b_d     = mac_b_o;
    mac_c_d     = mac_c_o;
    mac_sub_d   = mac_sub_o;
    count_d     = count_o;
    result_d    = result_o;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d       = init_i;
          remaining_d = length_i;
          mac_sub_d   = sub_i;
          count_d     = '0;
          nan_d       = 1'b0;
          state_d     = (length_i == '0) ? S_DONE : S_WAIT_ELEM;
        end
      end
      S_WAIT_ELEM: begin
        if (elem_valid_i) begin
          count_d = count_o + size_len'(1);
          if (nan_q) begin
            // Drain without touching the MAF: result is already NaN.
            remaining_d = remaining_q - size_len'(1);
            if (remaining_q == size_len'(1)) state_d = S_DONE;
          end else begin
            mac_a_d = a_i;
            mac_b_d = b_i;
            mac_c_d = acc_q;
            wait_d  = wait_w'(mac_latency);
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (wait_q != '0) begin
          wait_d = wait_q - wait_w'(1);
        end else begin
          acc_d       = mac_result_i;
          remaining_d = remaining_q - size_len'(1);
          nan_d       = res_nan;
          state_d     = (remaining_q == size_len'(1)) ? S_DONE : S_WAIT_ELEM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result is loaded on entry to DONE so it is valid alongside done_o.
    if (state_d == S_DONE) result_d = acc_d;

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_WAIT_ELEM);
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: self-checking bench for mac_dot_sequencer.
// Two DUTs (mac_latency 0 and 3), each with a behavioural floating-point MAF.
// A transaction-level model tracks accepted elements, the running
// accumulator, expected handshake and completion timing. Honours
// MAC_SEQ_NAN_EARLY_EXIT_EN when predicting the NaN drain behaviour.
`timescale 1ns/1ps
module tb_mac_dot_sequencer;

  localparam int unsigned W  = 34;
  localparam int unsigned LW = 8;
  typedef logic [W-1:0] word_t;
  localparam word_t NAN_WORD = 34'h37FC00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst        [2];
  logic          start      [2];
  logic [LW-1:0] length     [2];
  word_t         init       [2];
  logic          sub        [2];
  logic          elem_valid [2];
  logic          elem_ready [2];
  word_t         a          [2];
  word_t         b          [2];
  word_t         mac_a      [2];
  word_t         mac_b      [2];
  word_t         mac_c      [2];
  logic          mac_sub    [2];
  word_t         mac_res    [2];
  logic          busy       [2];
  logic          done       [2];
  word_t         result     [2];
  logic [LW-1:0] count      [2];

  word_t pipe [3];
  word_t op_a [16];
  word_t op_b [16];
  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mac_dot_sequencer #(.mac_latency(g == 0 ? 0 : 3)) dut (
      .clk(clk), .rst(rst[g]), .start_i(start[g]), .length_i(length[g]),
      .init_i(init[g]), .sub_i(sub[g]), .elem_valid_i(elem_valid[g]),
      .elem_ready_o(elem_ready[g]), .a_i(a[g]), .b_i(b[g]),
      .mac_a_o(mac_a[g]), .mac_b_o(mac_b[g]), .mac_c_o(mac_c[g]),
      .mac_sub_o(mac_sub[g]), .mac_result_i(mac_res[g]), .busy_o(busy[g]),
      .done_o(done[g]), .result_o(result[g]), .count_o(count[g])
    );
  end

  // Word <-> real conversion through IEEE double bit patterns.
  function automatic real w2r(input word_t w);
    logic [63:0] bits;
    if (w[33:32] == 2'b00) return 0.0;
    bits = {w[31], 11'(w[30:23]) + 11'd896, w[22:0], 29'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic word_t r2w(input real r);
    logic [63:0] bits;
    if (r == 0.0) return '0;
    bits = $realtobits(r);
    return {2'b01, bits[63], 8'(bits[62:52] - 11'd896), bits[51:29]};
  endfunction

  function automatic word_t maf(input word_t x, input word_t y, input word_t c, input logic s);
    real p;
    if (x[33:32] == 2'b11 || y[33:32] == 2'b11 || c[33:32] == 2'b11) return NAN_WORD;
    p = w2r(x) * w2r(y);
    return r2w(s ? w2r(c) - p : w2r(c) + p);
  endfunction

  function automatic word_t rand_word();
    return {2'b01, 1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // MAF models: combinational for DUT 0, three-stage pipeline for DUT 1.
  assign mac_res[0] = maf(mac_a[0], mac_b[0], mac_c[0], mac_sub[0]);
  always @(posedge clk) begin
    pipe[0] <= maf(mac_a[1], mac_b[1], mac_c[1], mac_sub[1]);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign mac_res[1] = pipe[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input int d);
    chk("rst_mac_a", 64'(mac_a[d]), 0);
    chk("rst_mac_b", 64'(mac_b[d]), 0);
    chk("rst_mac_c", 64'(mac_c[d]), 0);
    chk("rst_mac_sub", 64'(mac_sub[d]), 0);
    chk("rst_busy", 64'(busy[d]), 0);
    chk("rst_done", 64'(done[d]), 0);
    chk("rst_result", 64'(result[d]), 0);
    chk("rst_count", 64'(count[d]), 0);
    chk("rst_ready", 64'(elem_ready[d]), 0);
  endtask

  // Runs one vector, checking outputs every cycle against the model.
  task automatic run_vec(input int d, input int len, input word_t ini, input logic sb,
                         input int gapmax, input bit fixed_ops, input int nan_at,
                         output word_t res_out, output int done_cyc);
    int k, hold, cyc, gap;
    word_t acc, ia, ib, ic, na, nb;
    bit nanf, fin;
    @(posedge clk); #1;
    start[d] = 1'b1; length[d] = LW'(len); init[d] = ini; sub[d] = sb;
    elem_valid[d] = 1'b0;
    @(posedge clk); #1;
    k = 0; hold = 0; acc = ini; nanf = 1'b0; cyc = 1; done_cyc = -1;
    res_out = '0; fin = 1'b0; ia = '0; ib = '0; ic = '0;
    gap = int'($urandom_range(gapmax, 0));
    while (!fin) begin
      na = (fixed_ops && k < 16) ? op_a[k] : rand_word();
      nb = (fixed_ops && k < 16) ? op_b[k] : rand_word();
      if (k == nan_at) na = NAN_WORD;
      if (hold == 0 && k < len) elem_valid[d] = (gap == 0);
      else elem_valid[d] = ($urandom_range(1, 0) == 1);
      a[d] = na; b[d] = nb;
      // Commands issued while busy must be ignored.
      start[d]  = ($urandom_range(3, 0) == 0);
      length[d] = LW'($urandom);
      init[d]   = rand_word();
      sub[d]    = 1'($urandom);
      @(negedge clk);
      chk("busy", 64'(busy[d]), 1);
      if (k == len && hold == 0) begin
        chk("done_pulse", 64'(done[d]), 1);
        chk("done_result", 64'(result[d]), 64'(acc));
        chk("done_count", 64'(count[d]), 64'(len));
        chk("done_ready", 64'(elem_ready[d]), 0);
        res_out = result[d]; done_cyc = cyc; fin = 1'b1;
      end else begin
        chk("no_done", 64'(done[d]), 0);
        chk("ready", 64'(elem_ready[d]), 64'(hold == 0));
        chk("count", 64'(count[d]), 64'(k));
        chk("mac_sub", 64'(mac_sub[d]), 64'(sb));
        if (k > 0) begin
          chk("mac_a", 64'(mac_a[d]), 64'(ia));
          chk("mac_b", 64'(mac_b[d]), 64'(ib));
          chk("mac_c", 64'(mac_c[d]), 64'(ic));
        end
        if (hold > 0) begin
          hold--;
        end else if (elem_valid[d]) begin
          k++;
          if (!nanf) begin
            ia = na; ib = nb; ic = acc;
            acc = maf(na, nb, acc, sb);
            hold = lat_of(d) + 1;
`ifdef MAC_SEQ_NAN_EARLY_EXIT_EN
            nanf = (acc[33:32] == 2'b11);
`endif
          end
          gap = int'($urandom_range(gapmax, 0));
        end else if (gap > 0) begin
          gap--;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400 && !fin) begin
        chk("done_timeout", 1, 0);
        fin = 1'b1;
      end
    end
    start[d] = 1'b0; elem_valid[d] = 1'b0;
    @(negedge clk);
    chk("post_done", 64'(done[d]), 0);
    chk("post_busy", 64'(busy[d]), 0);
    chk("post_ready", 64'(elem_ready[d]), 0);
    chk("post_result", 64'(result[d]), 64'(acc));
  endtask

  word_t res;
  int    dc;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; length[d] = '0; init[d] = '0; sub[d] = 1'b0;
      elem_valid[d] = 1'b0; a[d] = '0; b[d] = '0;
    end
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    @(negedge clk);
    rst[0] = 1'b1; rst[1] = 1'b1;

    // Basic dot product: (1*2)+(2*2)+(1*3) = 9.0
    op_a[0] = 34'h13F800000; op_b[0] = 34'h140000000;
    op_a[1] = 34'h140000000; op_b[1] = 34'h140000000;
    op_a[2] = 34'h13F800000; op_b[2] = 34'h140400000;
    run_vec(0, 3, 34'h000000000, 1'b0, 0, 1'b1, -1, res, dc);
    chk("basic_result", 64'(res), 64'h141100000);
    chk("basic_done_cycle", 64'(dc), 7);

    // Empty vector
    run_vec(0, 0, 34'h140400000, 1'b0, 0, 1'b0, -1, res, dc);
    chk("empty_result", 64'(res), 64'h140400000);
    chk("empty_done_cycle", 64'(dc), 1);

    // Randomized vectors with producer gaps on both latencies
    for (int i = 0; i < 8; i++) begin
      run_vec(0, int'($urandom_range(8, 1)), rand_word(), 1'($urandom), 3, 1'b0, -1, res, dc);
      run_vec(1, int'($urandom_range(8, 1)), rand_word(), 1'($urandom), 3, 1'b0, -1, res, dc);
    end

    // Always-valid producer at latency 3: 1 + N*(3+2) cycles
    run_vec(1, 5, rand_word(), 1'b1, 0, 1'b0, -1, res, dc);
    chk("lat3_done_cycle", 64'(dc), 26);

    // Reset during ISSUE of element 2 of 4
    @(posedge clk); #1;
    start[1] = 1'b1; length[1] = LW'(4); init[1] = rand_word(); sub[1] = 1'b0;
    elem_valid[1] = 1'b1; a[1] = rand_word(); b[1] = rand_word();
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_count", 64'(count[1]), 2);
    chk("mid_ready", 64'(elem_ready[1]), 0);
    #2 rst[1] = 1'b0;
    #1 chk_zero(1);
    elem_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done[1]), 0);
      chk("abort_idle", 64'(busy[1]), 0);
    end
    run_vec(1, 4, rand_word(), 1'b0, 2, 1'b0, -1, res, dc);

    // NaN produced by element 1 of 4
    run_vec(1, 4, rand_word(), 1'b0, 0, 1'b0, 0, res, dc);
    chk("nan_result_exc", 64'(res[33:32]), 3);
`ifdef MAC_SEQ_NAN_EARLY_EXIT_EN
    chk("nan_done_cycle", 64'(dc), 9);
`else
    chk("nan_done_cycle", 64'(dc), 21);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
